// File: rtl/stuff_serializer.sv
// Word-to-bit serializer with HDLC-style zero-bit stuffing, a one-word holding buffer and raw (flag) words.
// Optional stuff-bit statistics counter enabled by defining STUFF_SERIALIZER_STATS_EN.
module stuff_serializer #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned STUFF_RUN = 5,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              strobe,
    input  logic              raw,
    input  logic              use_stuffing,
    output logic              ready,
    output logic              busy,
    output logic              data_out
`ifdef STUFF_SERIALIZER_STATS_EN
    ,
    input  logic              stats_clr,
    output logic [15:0]       stuff_count
`endif
);

    localparam int unsigned CNT_W = $clog2(DATA_W);
    localparam int unsigned RUN_W = 4;
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(STUFF_RUN);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_TAIL} state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   hold_q, hold_d;
    logic                hold_valid_q, hold_valid_d;
    logic                hold_stuff_q, hold_stuff_d;
    logic [DATA_W-1:0]   sh_q, sh_d;
    logic                sh_stuff_q, sh_stuff_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [RUN_W-1:0]    run_q, run_d;
    logic                dout_q, dout_d;
    logic                ready_q, busy_q;

    logic                cur_bit;
    logic [DATA_W-1:0]   sh_next;
    logic [RUN_W-1:0]    run_next;
    logic                load;

    // Next-state logic: shifter/FSM first, then the buffer accept (only possible when the buffer is empty)
    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        hold_stuff_d = hold_stuff_q;
        sh_d         = sh_q;
        sh_stuff_d   = sh_stuff_q;
        bit_cnt_d    = bit_cnt_q;
        run_d        = run_q;
        dout_d       = dout_q;
        load         = 1'b0;

        cur_bit  = MSB_FIRST ? sh_q[DATA_W-1] : sh_q[0];
        sh_next  = MSB_FIRST ? {sh_q[DATA_W-2:0], 1'b0} : {1'b0, sh_q[DATA_W-1:1]};
        run_next = (sh_stuff_q && cur_bit) ? RUN_W'(run_q + 1'b1) : '0;

        case (state_q)
            ST_IDLE: begin
                dout_d = 1'b1;
                run_d  = '0;
                if (hold_valid_q) begin
                    load    = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (run_q == RUN_MAX) begin
                    dout_d = 1'b0;
                    run_d  = '0;
                end else begin
                    dout_d    = cur_bit;
                    sh_d      = sh_next;
                    bit_cnt_d = CNT_W'(bit_cnt_q + 1'b1);
                    run_d     = run_next;
                    if (bit_cnt_q == LAST_BIT) begin
                        if (hold_valid_q) begin
                            load = 1'b1;
                        end else if (run_next == RUN_MAX) begin
                            state_d = ST_TAIL;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            ST_TAIL: begin
                dout_d = 1'b0;
                run_d  = '0;
                if (hold_valid_q) begin
                    load    = 1'b1;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load) begin
            sh_d         = hold_q;
            sh_stuff_d   = hold_stuff_q;
            bit_cnt_d    = '0;
            hold_valid_d = 1'b0;
        end

        if (strobe && !hold_valid_q) begin
            hold_d       = data_in;
            hold_stuff_d = use_stuffing && !raw;
            hold_valid_d = 1'b1;
        end
    end

    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            hold_stuff_q <= 1'b0;
            sh_q         <= '0;
            sh_stuff_q   <= 1'b0;
            bit_cnt_q    <= '0;
            run_q        <= '0;
            dout_q       <= 1'b1;
            ready_q      <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            hold_stuff_q <= hold_stuff_d;
            sh_q         <= sh_d;
            sh_stuff_q   <= sh_stuff_d;
            bit_cnt_q    <= bit_cnt_d;
            run_q        <= run_d;
            dout_q       <= dout_d;
            ready_q      <= !hold_valid_d;
            busy_q       <= (state_d != ST_IDLE);
        end
    end

    assign ready    = ready_q;
    assign busy     = busy_q;
    assign data_out = dout_q;

`ifdef STUFF_SERIALIZER_STATS_EN
    logic [15:0] stuff_cnt_q;

    // Count every inserted stuff zero (mid-word and trailing); clear beats increment
    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stuff_cnt_q <= '0;
        end else if (stats_clr) begin
            stuff_cnt_q <= '0;
        end else if (((state_q == ST_SHIFT) && (run_q == RUN_MAX)) || (state_q == ST_TAIL)) begin
            if (stuff_cnt_q != 16'hFFFF) begin
                stuff_cnt_q <= 16'(stuff_cnt_q + 1'b1);
            end
        end
    end

    assign stuff_count = stuff_cnt_q;
`endif

endmodule

// File: tb/tb_stuff_serializer.sv
// Scoreboard bench for stuff_serializer: expected line bits are queued with each stimulus and popped per falling edge.
module tb_stuff_serializer;

    logic       clk;
    logic       reset_n;
    logic [7:0] data_in;
    logic       strobe;
    logic       raw;
    logic       use_stuffing;
    logic       ready;
    logic       busy;
    logic       data_out;
`ifdef STUFF_SERIALIZER_STATS_EN
    logic        stats_clr;
    logic [15:0] stuff_count;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    bit exp_q[$];

    stuff_serializer #(.DATA_W(8), .STUFF_RUN(5), .MSB_FIRST(1'b1)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .data_in      (data_in),
        .strobe       (strobe),
        .raw          (raw),
        .use_stuffing (use_stuffing),
        .ready        (ready),
        .busy         (busy),
        .data_out     (data_out)
`ifdef STUFF_SERIALIZER_STATS_EN
        ,
        .stats_clr    (stats_clr),
        .stuff_count  (stuff_count)
`endif
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, want);
    endtask

    task automatic push_bits(input logic [31:0] v, input int n);
        logic [31:0] tmp;
        tmp = v;
        for (int i = n - 1; i >= 0; i--) exp_q.push_back(tmp[i]);
    endtask

    // Called one time unit after a falling edge; returns one time unit after the accepting edge
    task automatic send_word(input logic [7:0] d, input logic r, input logic s);
        bit done;
        done = 1'b0;
        data_in = d; raw = r; use_stuffing = s; strobe = 1'b1;
        for (int i = 0; i < 60 && !done; i++) begin
            if (ready) done = 1'b1;
            @(negedge clk);
            #1;
        end
        strobe = 1'b0;
        if (!done) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    // Starts one time unit after the accepting edge; first bit arrives two edges later
    task automatic check_stream(input string tag, input int n, input int busy_exp);
        int  bcnt;
        bit  e;
        @(negedge clk); #1;
        bcnt = busy ? 1 : 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk); #1;
            bcnt += busy ? 1 : 0;
            if (exp_q.size() == 0) begin
                chk($sformatf("%s_qempty", tag), 32'd0, 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk($sformatf("%s_bit%0d", tag, i), 32'(data_out), 32'(e));
            end
        end
        @(negedge clk); #1;
        chk($sformatf("%s_idle_line", tag), 32'(data_out), 32'd1);
        chk($sformatf("%s_idle_busy", tag), 32'(busy), 32'd0);
        if (busy_exp >= 0) chk($sformatf("%s_busy_edges", tag), 32'(bcnt), 32'(busy_exp));
    endtask

    task automatic gap();
        repeat (3) @(negedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; strobe = 1'b0; raw = 1'b0; use_stuffing = 1'b1; data_in = '0;
`ifdef STUFF_SERIALIZER_STATS_EN
        stats_clr = 1'b0;
`endif
        #12;
        chk("rst_line", 32'(data_out), 32'd1);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        #10 reset_n = 1'b1;
        @(negedge clk); #1;

        // 0xA5, stuffing on
        push_bits(32'hA5, 8);
        send_word(8'hA5, 1'b0, 1'b1);
        check_stream("a5", 8, 8);
        gap();

        // 0xFF with and without stuffing
        push_bits(32'b111110111, 9);
        send_word(8'hFF, 1'b0, 1'b1);
        check_stream("ff_stuff", 9, -1);
        gap();
        push_bits(32'hFF, 8);
        send_word(8'hFF, 1'b0, 1'b0);
        check_stream("ff_nostuff", 8, 8);
        gap();

        // Back-to-back 0x0F, 0xF0: stuff crosses the word boundary
        push_bits(32'b00001111101110000, 17);
        send_word(8'h0F, 1'b0, 1'b1);
        fork
            check_stream("b2b", 17, -1);
            begin
                chk("b2b_ready_before", 32'(ready), 32'd0);
                send_word(8'hF0, 1'b0, 1'b1);
                chk("b2b_ready_held", 32'(ready), 32'd0);
                repeat (7) @(negedge clk);
                #1;
                chk("b2b_ready_drained", 32'(ready), 32'd1);
            end
        join
        gap();

        // Trailing stuff via TAIL
        push_bits(32'b000111110, 9);
        send_word(8'h1F, 1'b0, 1'b1);
        check_stream("tail", 9, 9);
        gap();

        // 0x0F, raw flag 0x7E, then stuffed 0xFF with the run restarted
        push_bits(32'b0000111101111110111110111, 25);
        send_word(8'h0F, 1'b0, 1'b1);
        fork
            check_stream("raw", 25, -1);
            begin
                send_word(8'h7E, 1'b1, 1'b1);
                send_word(8'hFF, 1'b0, 1'b1);
            end
        join
        gap();

`ifdef STUFF_SERIALIZER_STATS_EN
        chk("stats_count", 32'(stuff_count), 32'd4);
        stats_clr = 1'b1;
        @(negedge clk); #1;
        stats_clr = 1'b0;
        chk("stats_clr", 32'(stuff_count), 32'd0);
`endif

        // Reset mid-word after three bits of 0x00
        send_word(8'h00, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        #1;
        chk("mid_bit", 32'(data_out), 32'd0);
        chk("mid_busy", 32'(busy), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_line", 32'(data_out), 32'd1);
        chk("mid_rst_ready", 32'(ready), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        @(negedge clk); #1;
        chk("mid_rst_hold_line", 32'(data_out), 32'd1);
        reset_n = 1'b1;
        @(negedge clk); #1;
        push_bits(32'b111110111, 9);
        send_word(8'hFF, 1'b0, 1'b1);
        check_stream("post_rst", 9, -1);
`ifdef STUFF_SERIALIZER_STATS_EN
        chk("stats_post_rst", 32'(stuff_count), 32'd1);
`endif
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
